// File: rtl/alu_pkg.sv
// Shared ALU definitions: shift op encodings
// and the shift unit's FSM state type.
package alu_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/shift_unit_iter_stage.sv
// One fixed-distance log-shifter stage.
// Passes data through untouched when en is low.
module shift_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic             en,
  input  logic [1:0]       op,
  input  logic             fill_bit,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  // shift by DIST with per-op fill
  always_comb begin
    data_o = data_i;
    if (en) begin
      unique case (op)
        OP_SLL: data_o = {data_i[WIDTH-DIST-1:0],
                          {DIST{1'b0}}};
        OP_SRL: data_o = {{DIST{1'b0}},
                          data_i[WIDTH-1:DIST]};
        OP_SRA: data_o = {{DIST{fill_bit}},
                          data_i[WIDTH-1:DIST]};
        default: data_o = {data_i[DIST-1:0],
                           data_i[WIDTH-1:DIST]};
      endcase
    end
  end

endmodule

// File: rtl/shift_unit_iter.sv
// Multi-cycle shift unit: a shared log-shifter
// walked STAGES_PER_CYCLE stages per clock.
module shift_unit_iter
  import alu_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int STAGES_PER_CYCLE = 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               op,
  input  logic [WIDTH-1:0]         data_in,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         data_out
);

  localparam int LOG_W = $clog2(WIDTH);
  localparam int SPC   = STAGES_PER_CYCLE;
  localparam int KW    = LOG_W + 1;

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [1:0]       op_q;
  logic [LOG_W-1:0] sh_q;
  logic             fill_q;
  logic [KW-1:0]    k;

  // chain[LOG_W] is the working reg; chain[0]
  // is the value after this cycle's window.
  // Only stages k..k-SPC+1 are enabled, so
  // exactly SPC distances act per cycle,
  // largest first.
  logic [WIDTH-1:0] chain [LOG_W+1];

  assign chain[LOG_W] = work;

  for (genvar d = 0; d < LOG_W; d++) begin : g_stage
    logic en;
    assign en = sh_q[d]
             && (k >= KW'(d))
             && (k < KW'(d + SPC));
    shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << d)
    ) u_stage (
      .en       (en),
      .op       (op_q),
      .fill_bit (fill_q),
      .data_i   (chain[d+1]),
      .data_o   (chain[d])
    );
  end

  // FSM, operand latches and handshakes
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      data_out  <= '0;
      work      <= '0;
      op_q      <= OP_SLL;
      sh_q      <= '0;
      fill_q    <= 1'b0;
      k         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            work     <= data_in;
            op_q     <= op;
            sh_q     <= shamt;
            fill_q   <= data_in[WIDTH-1];
            k        <= KW'(LOG_W - 1);
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          work <= chain[0];
          if (k < KW'(SPC)) begin
            data_out  <= chain[0];
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            k <= k - KW'(SPC);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
